receiver_interface: RTL

Receive-side companion to the transmitter interface. It accepts bytes from the UART receiver, discards frames flagged as bad, and buffers good bytes in a small synchronous FIFO. It exposes a registered pop port to the downstream consumer. It also drives the FIFO status flags (`empty_led`, `filled_led`) that the transmit side turns into status characters, plus sticky overflow and error-count diagnostics.

---
 rtl/receiver_interface.sv | 108 ++++++++++
 1 files changed

// File: rtl/receiver_interface.sv
// rtl/receiver_interface.sv - receive-side FIFO buffer with framing-error filter and status flags
module receiver_interface #(
  parameter int Word_Len = 8,
  parameter int Depth    = 16,
  parameter int Addr_Len = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [Word_Len-1:0] From_Receiver,
  input  logic                rx_valid,
  input  logic                rx_frame_err,
  input  logic                rd_en,
  input  logic                clr_ovf,
  output logic [Word_Len-1:0] rd_data,
  output logic                rd_valid,
  output logic                empty_led,
  output logic                filled_led,
  output logic                overflow,
  output logic [7:0]          err_count,
  output logic [Addr_Len:0]   level
);

  localparam logic [Addr_Len:0] LP_FULL = (Addr_Len+1)'(Depth);

  logic [Word_Len-1:0] r_mem [Depth];
  logic [Addr_Len-1:0] r_wp;
  logic [Addr_Len-1:0] r_rp;
  logic [Addr_Len:0]   r_level;
  logic                r_empty;
  logic                r_filled;
  logic [Word_Len-1:0] r_rd_data;
  logic                r_rd_valid;
  logic                r_overflow;
  logic [7:0]          r_err_count;

  logic                w_good;
  logic                w_wr;
  logic                w_drop;
  logic                w_rd;
  logic                w_err;
  logic [Addr_Len:0]   w_level_nxt;

  // Full/empty are judged on the pre-edge registered flags, so a same-edge
  // pop never makes room for a write and a write is never bypassed to a pop.
  assign w_good = rx_valid & ~rx_frame_err;
  assign w_wr   = w_good & ~r_filled;
  assign w_drop = w_good & r_filled;
  assign w_rd   = rd_en & ~r_empty;
  assign w_err  = rx_valid & rx_frame_err;

  always_comb begin
    w_level_nxt = r_level;
    case ({w_wr, w_rd})
      2'b10:   w_level_nxt = r_level + 1'b1;
      2'b01:   w_level_nxt = r_level - 1'b1;
      default: w_level_nxt = r_level;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wp] <= From_Receiver;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wp        <= '0;
      r_rp        <= '0;
      r_level     <= '0;
      r_empty     <= 1'b1;
      r_filled    <= 1'b0;
      r_rd_data   <= '0;
      r_rd_valid  <= 1'b0;
      r_overflow  <= 1'b0;
      r_err_count <= '0;
    end else begin
      if (w_wr) begin
        r_wp <= r_wp + 1'b1;
      end
      if (w_rd) begin
        r_rd_data <= r_mem[r_rp];
        r_rp      <= r_rp + 1'b1;
      end
      r_rd_valid <= w_rd;
      r_level    <= w_level_nxt;
      r_empty    <= (w_level_nxt == '0);
      r_filled   <= (w_level_nxt == LP_FULL);
      if (w_drop) begin
        r_overflow <= 1'b1;
      end else if (clr_ovf) begin
        r_overflow <= 1'b0;
      end
      if (w_err && (r_err_count != 8'hFF)) begin
        r_err_count <= r_err_count + 8'd1;
      end
    end
  end

  assign rd_data    = r_rd_data;
  assign rd_valid   = r_rd_valid;
  assign empty_led  = r_empty;
  assign filled_led = r_filled;
  assign overflow   = r_overflow;
  assign err_count  = r_err_count;
  assign level      = r_level;

endmodule
